// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared constants and types for the 5-bit LFSR sequence checker
package lfsr_pkg;

  localparam int LFSR_W = 5;

  // Feedback from bit 4 lands on bits 2 and 0 after the left shift (x^5+x^2+1)
  localparam logic [LFSR_W-1:0] LFSR_FB_MASK = 5'b00101;

  localparam logic [5:0] PERIOD_MAX = 6'd63;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_LOCKUP  = 2'd3
  } chk_state_t;

endpackage

// File: rtl/lfsr_seq_checker_if.sv
// rtl/lfsr_seq_checker_if.sv - sample stream from the upstream LFSR into the checker
interface lfsr_seq_checker_if;
  import lfsr_pkg::*;

  logic              in_valid;
  logic [LFSR_W-1:0] lfsr_in;

  modport master (output in_valid, output lfsr_in);
  modport slave  (input  in_valid, input  lfsr_in);

endinterface

// File: rtl/lfsr5_next.sv
// rtl/lfsr5_next.sv - combinational next-state of the 5-bit internal-XOR LFSR
module lfsr5_next
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] s,
  output logic [LFSR_W-1:0] n
);

  assign n = {s[LFSR_W-2:0], 1'b0} ^ (s[LFSR_W-1] ? LFSR_FB_MASK : '0);

endmodule

// File: rtl/lfsr_seq_checker.sv
// rtl/lfsr_seq_checker.sv - LFSR sequence checker with lock, error count and period measurement; LFSR_CHK_RESYNC_EN enables resync
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter int ERR_W      = 8,
  parameter int MISS_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [LFSR_W-1:0] lfsr_in,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic              lockup,
  output logic [5:0]        period,
  output logic              period_valid
);

  chk_state_t        state_q;
  logic [LFSR_W-1:0] ref_q;
  logic [LFSR_W-1:0] prev_q;
  logic [5:0]        cnt_q;
  logic [5:0]        period_q;
  logic              period_valid_q;
  logic [ERR_W-1:0]  err_count_q;
  logic              err_pulse_q;
  logic              lockup_q;
  logic              locked_q;

  logic [LFSR_W-1:0] exp_next;
  logic              mismatch;

  lfsr5_next u_next (
    .s (prev_q),
    .n (exp_next)
  );

  assign mismatch = (lfsr_in != exp_next);

`ifdef LFSR_CHK_RESYNC_EN
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);
  logic [MISS_W-1:0] miss_q;
`else
  logic unused_miss_limit;
  assign unused_miss_limit = ^MISS_LIMIT;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      ref_q          <= '0;
      prev_q         <= '0;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      err_count_q    <= '0;
      err_pulse_q    <= 1'b0;
      lockup_q       <= 1'b0;
      locked_q       <= 1'b0;
`ifdef LFSR_CHK_RESYNC_EN
      miss_q         <= '0;
`endif
    end else begin
      err_pulse_q <= 1'b0;
      if (in_valid) begin
        // An all-zero word means the upstream LFSR is stuck; it overrides every state
        if (lfsr_in == '0) begin
          state_q  <= ST_LOCKUP;
          lockup_q <= 1'b1;
          locked_q <= 1'b0;
        end else begin
          case (state_q)
            ST_IDLE, ST_LOCKUP: begin
              state_q        <= ST_ACQUIRE;
              locked_q       <= 1'b0;
              err_count_q    <= '0;
              period_q       <= '0;
              period_valid_q <= 1'b0;
            end
            ST_ACQUIRE: begin
              state_q  <= ST_TRACK;
              locked_q <= 1'b1;
              ref_q    <= lfsr_in;
              prev_q   <= lfsr_in;
              cnt_q    <= 6'd1;
`ifdef LFSR_CHK_RESYNC_EN
              miss_q   <= '0;
`endif
            end
            ST_TRACK: begin
              prev_q      <= lfsr_in;
              err_pulse_q <= mismatch;
              if (mismatch && (err_count_q != '1))
                err_count_q <= err_count_q + ERR_W'(1);
              // Counting stops once a period is captured or the counter saturates
              if (!period_valid_q && (cnt_q != PERIOD_MAX)) begin
                if (!mismatch && (lfsr_in == ref_q)) begin
                  period_q       <= cnt_q;
                  period_valid_q <= 1'b1;
                end else begin
                  cnt_q <= cnt_q + 6'd1;
                end
              end
`ifdef LFSR_CHK_RESYNC_EN
              if (mismatch) begin
                if (miss_q == MISS_W'(MISS_LIMIT - 1)) begin
                  state_q        <= ST_ACQUIRE;
                  locked_q       <= 1'b0;
                  err_count_q    <= '0;
                  period_q       <= '0;
                  period_valid_q <= 1'b0;
                  miss_q         <= '0;
                end else begin
                  miss_q <= miss_q + MISS_W'(1);
                end
              end else begin
                miss_q <= '0;
              end
`endif
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign locked       = locked_q;
  assign err_pulse    = err_pulse_q;
  assign err_count    = err_count_q;
  assign lockup       = lockup_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// tb/tb_lfsr_seq_checker.sv - self-checking bench for lfsr_seq_checker
module tb_lfsr_seq_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       locked, err_pulse, lockup, period_valid;
  logic [7:0] err_count;
  logic [5:0] period;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic lk;
    logic ep;
  } exp_t;
  exp_t sb[$];

  lfsr_seq_checker_if bus ();

  lfsr_seq_checker #(.ERR_W(8), .MISS_LIMIT(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (bus.in_valid),
    .lfsr_in      (bus.lfsr_in),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .err_count    (err_count),
    .lockup       (lockup),
    .period       (period),
    .period_valid (period_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_nxt(input logic [4:0] s);
    return {s[3], s[2], s[1] ^ s[4], s[0], s[4]};
  endfunction

  // Called at posedge+1; applies one cycle of stimulus and checks the registered response
  task automatic step(input logic v, input logic [4:0] d, input logic lk, input logic ep);
    exp_t e;
    bus.in_valid = v;
    bus.lfsr_in  = d;
    e.lk = lk;
    e.ep = ep;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    vectors++;
    if (locked !== e.lk) begin
      miscompares++;
      $display("FAIL locked: got %b want %b at %0t", locked, e.lk, $time);
    end
    vectors++;
    if (err_pulse !== e.ep) begin
      miscompares++;
      $display("FAIL err_pulse: got %b want %b at %0t", err_pulse, e.ep, $time);
    end
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.lfsr_in  = 5'd0;
    #20;
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    if ({locked, err_pulse, err_count, lockup, period, period_valid} !== 18'd0) begin
      miscompares++;
      $display("FAIL %s outputs: got lk=%b ep=%b ec=%0d lu=%b per=%0d pv=%b want all 0",
               tag, locked, err_pulse, err_count, lockup, period, period_valid);
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.lfsr_in  = 5'd0;
    @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_lock_period();
    logic [4:0] s = 5'b00001;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step(1'b1, s, i >= 1, 1'b0);
      s = ref_nxt(s);
    end
    step(1'b0, 5'd0, 1'b1, 1'b0);
    vectors++;
    if (period !== 6'd31 || period_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL lock_period: got period=%0d pv=%b want 31/1", period, period_valid);
    end
    vectors++;
    if (err_count !== 8'd0 || lockup !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_errs: got ec=%0d lu=%b want 0/0", err_count, lockup);
    end
  endtask

  task automatic test_error_inject();
    logic [4:0] s = 5'b00001;
    logic [4:0] d;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      d = (i == 11) ? (s ^ 5'b00100) : s;
      step(1'b1, d, i >= 1, (i == 11) || (i == 12));
      s = ref_nxt(s);
    end
    vectors++;
    if (err_count !== 8'd2 || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL error_inject: got ec=%0d lk=%b want 2/1", err_count, locked);
    end
    vectors++;
    if (period !== 6'd31 || period_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL error_inject_period: got period=%0d pv=%b want 31/1", period, period_valid);
    end
  endtask

  task automatic test_lockup();
    logic [4:0] s = 5'b00001;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, s, i >= 1, 1'b0);
      s = ref_nxt(s);
    end
    vectors++;
    if (lockup !== 1'b0) begin
      miscompares++;
      $display("FAIL lockup_pre: got %b want 0", lockup);
    end
    step(1'b1, 5'd0, 1'b0, 1'b0);
    vectors++;
    if (lockup !== 1'b1) begin
      miscompares++;
      $display("FAIL lockup_set: got %b want 1", lockup);
    end
    step(1'b1, s, 1'b0, 1'b0);
    s = ref_nxt(s);
    step(1'b1, s, 1'b1, 1'b0);
    s = ref_nxt(s);
    step(1'b1, s, 1'b1, 1'b0);
    vectors++;
    if (lockup !== 1'b1 || err_count !== 8'd0) begin
      miscompares++;
      $display("FAIL lockup_sticky: got lu=%b ec=%0d want 1/0", lockup, err_count);
    end
  endtask

  task automatic test_resync();
    logic [4:0] s = 5'b00001;
    logic [4:0] prev, w, e;
    logic lk;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, s, i >= 1, 1'b0);
      prev = s;
      s = ref_nxt(s);
    end
    for (int k = 0; k < 3; k++) begin
      e = ref_nxt(prev);
      w = 5'($urandom_range(1, 31));
      while (w == e) w = 5'($urandom_range(1, 31));
`ifdef LFSR_CHK_RESYNC_EN
      lk = (k < 2);
`else
      lk = 1'b1;
`endif
      step(1'b1, w, lk, 1'b1);
      prev = w;
    end
`ifdef LFSR_CHK_RESYNC_EN
    step(1'b0, 5'd0, 1'b0, 1'b0);
    vectors++;
    if (err_count !== 8'd0) begin
      miscompares++;
      $display("FAIL resync_count: got %0d want 0", err_count);
    end
    step(1'b1, 5'b01011, 1'b1, 1'b0);
    step(1'b1, ref_nxt(5'b01011), 1'b1, 1'b0);
`else
    step(1'b0, 5'd0, 1'b1, 1'b0);
    vectors++;
    if (err_count !== 8'd3) begin
      miscompares++;
      $display("FAIL resync_count: got %0d want 3", err_count);
    end
    step(1'b1, ref_nxt(prev), 1'b1, 1'b0);
`endif
  endtask

  task automatic test_gapped();
    logic [4:0] s = 5'b00001;
    int n = 0;
    do_reset();
    for (int c = 0; c < 80; c++) begin
      if ((c % 2) == 0) begin
        step(1'b1, s, n >= 1, 1'b0);
        n++;
        s = ref_nxt(s);
      end else begin
        step(1'b0, 5'($urandom_range(0, 31)), n >= 2, 1'b0);
      end
    end
    vectors++;
    if (period !== 6'd31 || period_valid !== 1'b1 || err_count !== 8'd0) begin
      miscompares++;
      $display("FAIL gapped: got period=%0d pv=%b ec=%0d want 31/1/0", period, period_valid, err_count);
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] s = 5'b00001;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, (i == 4) ? (s ^ 5'b00100) : s, i >= 1, (i == 4) || (i == 5));
      s = ref_nxt(s);
    end
    vectors++;
    if (err_count !== 8'd2 || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL async_pre: got ec=%0d lk=%b want 2/1", err_count, locked);
    end
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    s = 5'b00001;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, s, i >= 1, 1'b0);
      s = ref_nxt(s);
    end
    vectors++;
    if (err_count !== 8'd0 || lockup !== 1'b0) begin
      miscompares++;
      $display("FAIL async_relock: got ec=%0d lu=%b want 0/0", err_count, lockup);
    end
  endtask

  initial begin
    test_reset();
    test_lock_period();
    test_error_inject();
    test_lockup();
    test_resync();
    test_gapped();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_checker.md
LFSR_SEQ_CHECKER -- requirements
Module: lfsr_seq_checker

Interface
- REQ-001 SHALL have parameter ERR_W, default 8: width of the saturating error counter.
- REQ-002 SHALL have parameter MISS_LIMIT, default 3: consecutive-mismatch threshold, used only when LFSR_CHK_RESYNC_EN is defined.
- REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
- REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
- REQ-005 SHALL have port in_valid, input, 1: lfsr_in carries a sample this cycle.
- REQ-006 SHALL have port lfsr_in, input, 5: state word from the upstream 5-bit internal-XOR LFSR (Sout).
- REQ-007 SHALL have port locked, output, 1: checker is in TRACK.
- REQ-008 SHALL have port err_pulse, output, 1: one-cycle pulse per mismatching sample.
- REQ-009 SHALL have port err_count, output, ERR_W: mismatches since lock; saturates at all-ones.
- REQ-010 SHALL have port lockup, output, 1: sticky flag for an all-zero sample.
- REQ-011 SHALL have port period, output, 6: measured sequence period.
- REQ-012 SHALL have port period_valid, output, 1: period holds a valid measurement (sticky until re-acquire).

Function
- REQ-013 SHALL compute the next-state function nxt(s) = {s[3], s[2], s[1]^s[4], s[0], s[4]} (bits 4..0), matching the upstream LFSR (x^5+x^2+1).
- REQ-014 SHALL implement FSM states IDLE, ACQUIRE, TRACK and LOCKUP; only samples with in_valid=1 advance the FSM.
- REQ-015 IDLE: on the first valid sample, go to ACQUIRE.
- REQ-016 ACQUIRE: on the next valid nonzero sample, store it as ref and prev, clear the period counter to 1, and go to TRACK.
- REQ-017 TRACK: for each valid sample, compare it with nxt(prev); on mismatch, pulse err_pulse in the following cycle and increment err_count (saturating); prev SHALL always load the received sample.
- REQ-018 TRACK: on a valid sample equal to ref, with period_valid=0 and no mismatch on that sample, load period with the counter value, set period_valid, and stop counting.
- REQ-019 The period counter SHALL saturate at 63; if it reaches 63 without a match, period SHALL stay 0 and period_valid SHALL stay 0.
- REQ-020 A valid all-zero sample in any state SHALL set lockup, go to LOCKUP and clear locked; LOCKUP SHALL exit to ACQUIRE only on a valid nonzero sample.
- REQ-021 Output latency SHALL be 1 cycle from a sampled in_valid to err_pulse, locked and period updates.
- REQ-022 Entry to ACQUIRE SHALL clear err_count, period and period_valid; lockup SHALL clear only on reset.
- REQ-023 A cycle with in_valid=0 SHALL hold all state; err_pulse SHALL be 0 in that cycle.

Reset
- REQ-024 While rst_n=0, the block SHALL be in IDLE with locked=0, err_pulse=0, err_count=0, lockup=0, period=0, period_valid=0, and ref/prev=0.
- REQ-025 Reset assertion mid-TRACK SHALL take effect immediately (asynchronously); after release, the checker SHALL re-acquire from IDLE.

Configuration
- REQ-026 SHALL support macro LFSR_CHK_RESYNC_EN.
- REQ-027 With LFSR_CHK_RESYNC_EN defined: MISS_LIMIT consecutive mismatches in TRACK SHALL force ACQUIRE (locked drops the next cycle); any match SHALL reset the run counter.
- REQ-028 Without LFSR_CHK_RESYNC_EN: the block SHALL stay in TRACK regardless of mismatches, and no run counter SHALL exist.

Structure
- REQ-029 Package lfsr_pkg SHALL hold LFSR_W=5, the tap constant, the FSM state typedef, and the PERIOD_MAX=63 constant.
- REQ-030 The next-state function SHALL be a combinational sub-module lfsr5_next (input s[4:0], output n[4:0]), also reusable by the upstream generator's model.

Verification
- REQ-031 Seed 5'b00001, upstream LFSR free-running, in_valid=1 -> locked=1 two cycles after the first valid sample; period=31 with period_valid=1; err_count=0.
- REQ-032 In TRACK, bit 2 of one sample forced flipped -> two err_pulse cycles; err_count=2; locked stays 1.
- REQ-033 lfsr_in=5'b00000 with in_valid=1 -> lockup=1 and locked=0 next cycle; a subsequent nonzero sample -> ACQUIRE, then TRACK.
- REQ-034 With LFSR_CHK_RESYNC_EN, 3 consecutive random wrong samples -> locked=0 next cycle, err_count cleared on re-acquire; without the macro -> locked stays 1 and err_count=3.
- REQ-035 in_valid toggling 1/0 every cycle -> same period=31 result, no err_pulse during gaps.
- REQ-036 rst_n pulsed low mid-TRACK between clock edges -> all outputs 0 immediately; re-lock after release.
